// File: rtl/tt_inciso2_pkg.sv
// tt_inciso2_pkg: shared state encoding, sweep geometry and golden table
// for the Inciso 2 truth-table scanner.
package tt_inciso2_pkg;

    localparam int NUM_VECTORS = 32;
    localparam int IDX_W       = 5;
    localparam logic [NUM_VECTORS-1:0] EXPECTED_INCISO2 = 32'h0A3F_8C7F;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT,
        S_SAMPLE,
        S_FIN,
        S_DONE
    } state_t;

endpackage

// File: rtl/tt_scanner_inciso2_settle_cnt.sv
// tt_settle_cnt: loadable 4-bit down-counter with zero flag, used to time
// the settle window between driving a vector and sampling F.
module tt_settle_cnt (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic       i_dec,
    input  logic [3:0] i_val,
    output logic       o_zero
);

    logic [3:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_cnt <= 4'd0;
        else if (i_load)
            r_cnt <= i_val;
        else if (i_dec && r_cnt != 4'd0)
            r_cnt <= r_cnt - 4'd1;
    end

    assign o_zero = (r_cnt == 4'd0);

endmodule

// File: rtl/tt_scanner_inciso2.sv
// tt_scanner_inciso2: sweeps all 32 {X,Y,Z,K,M} vectors into the function
// block, records F_Final per vector and compares it against a golden table.
module tt_scanner_inciso2
    import tt_inciso2_pkg::*;
#(
    parameter int                      SETTLE   = 1,
    parameter logic [NUM_VECTORS-1:0]  EXPECTED = EXPECTED_INCISO2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   f_in,
    output logic                   x_o,
    output logic                   y_o,
    output logic                   z_o,
    output logic                   k_o,
    output logic                   m_o,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [NUM_VECTORS-1:0] truth_table,
    output logic [5:0]             mismatch_cnt,
    output logic [IDX_W-1:0]       first_fail,
    output logic                   first_fail_vld
);

    // The counter holds the WAIT cycles remaining after the current one,
    // so WAIT lasts exactly SETTLE cycles and exits on the zero flag.
    localparam logic [3:0] LOAD_VAL = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);

    state_t                 r_state;
    logic [IDX_W-1:0]       r_idx;
    logic [IDX_W-1:0]       r_vec;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_pass;
    logic [NUM_VECTORS-1:0] r_tt;
    logic [5:0]             r_mcnt;
    logic [IDX_W-1:0]       r_ff;
    logic                   r_ffv;
    logic                   w_zero;
    logic                   w_miss;

    assign w_miss = (f_in != EXPECTED[r_idx]);

    tt_settle_cnt u_settle (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (r_state == S_DRIVE),
        .i_dec  (r_state == S_WAIT),
        .i_val  (LOAD_VAL),
        .o_zero (w_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_vec   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_tt    <= '0;
            r_mcnt  <= '0;
            r_ff    <= '0;
            r_ffv   <= 1'b0;
        end else if (abort && r_busy) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state <= S_DRIVE;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_pass  <= 1'b0;
                        r_tt    <= '0;
                        r_mcnt  <= '0;
                        r_ff    <= '0;
                        r_ffv   <= 1'b0;
                    end
                end
                S_DRIVE: begin
                    r_vec   <= r_idx;
                    r_state <= (SETTLE == 0) ? S_SAMPLE : S_WAIT;
                end
                S_WAIT: begin
                    if (w_zero)
                        r_state <= S_SAMPLE;
                end
                S_SAMPLE: begin
                    r_tt[r_idx] <= f_in;
                    if (w_miss) begin
                        r_mcnt <= r_mcnt + 6'd1;
                        if (!r_ffv) begin
                            r_ff  <= r_idx;
                            r_ffv <= 1'b1;
                        end
                    end
                    if (r_idx == IDX_W'(NUM_VECTORS - 1)) begin
                        r_state <= S_FIN;
                        r_busy  <= 1'b0;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                        r_state <= S_DRIVE;
                    end
                end
                S_FIN: begin
                    r_pass  <= (r_mcnt == 6'd0);
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign {x_o, y_o, z_o, k_o, m_o} = r_vec;
    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign truth_table    = r_tt;
    assign mismatch_cnt   = r_mcnt;
    assign first_fail     = r_ff;
    assign first_fail_vld = r_ffv;

endmodule

// File: tb/tb_tt_scanner_inciso2.sv
// tb_tt_scanner_inciso2: directed bench for the truth-table scanner; the
// function block is modelled as a lookup table indexed by the driven vector.
module tb_tt_scanner_inciso2;

    localparam logic [31:0] GOLD = 32'h0A3F_8C7F;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    logic abort = 1'b0;
    logic start_a = 1'b0, start_b = 1'b0;
    logic [31:0] model_a = GOLD, model_b = GOLD;

    logic a_x, a_y, a_z, a_k, a_m, a_busy, a_done, a_pass, a_ffv;
    logic b_x, b_y, b_z, b_k, b_m, b_busy, b_done, b_pass, b_ffv;
    logic [31:0] a_tt, b_tt;
    logic [5:0] a_mcnt, b_mcnt;
    logic [4:0] a_ff, b_ff;
    logic [4:0] a_vec, b_vec;
    logic a_f, b_f;

    assign a_vec = {a_x, a_y, a_z, a_k, a_m};
    assign b_vec = {b_x, b_y, b_z, b_k, b_m};
    assign a_f = model_a[a_vec];
    assign b_f = model_b[b_vec];

    int checks = 0;
    int errors = 0;

    tt_scanner_inciso2 #(.SETTLE(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort), .f_in(a_f),
        .x_o(a_x), .y_o(a_y), .z_o(a_z), .k_o(a_k), .m_o(a_m),
        .busy(a_busy), .done(a_done), .pass(a_pass), .truth_table(a_tt),
        .mismatch_cnt(a_mcnt), .first_fail(a_ff), .first_fail_vld(a_ffv)
    );

    tt_scanner_inciso2 #(.SETTLE(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort), .f_in(b_f),
        .x_o(b_x), .y_o(b_y), .z_o(b_z), .k_o(b_k), .m_o(b_m),
        .busy(b_busy), .done(b_done), .pass(b_pass), .truth_table(b_tt),
        .mismatch_cnt(b_mcnt), .first_fail(b_ff), .first_fail_vld(b_ffv)
    );

    task automatic run_a(output int cyc, output int bsy);
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        cyc = 0;
        bsy = 0;
        while (!a_done && cyc < 200) begin
            if (a_busy) bsy++;
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({a_busy, a_done, a_pass, a_ffv} !== 4'b0) begin
            errors++; $display("FAIL reset_flags_a got %b want 0000", {a_busy, a_done, a_pass, a_ffv});
        end
        checks++;
        if (a_tt !== 32'h0 || a_mcnt !== 6'd0 || a_ff !== 5'd0 || a_vec !== 5'd0) begin
            errors++; $display("FAIL reset_data_a tt=%h mcnt=%0d ff=%0d vec=%0d want all 0", a_tt, a_mcnt, a_ff, a_vec);
        end
        checks++;
        if ({b_busy, b_done, b_pass, b_ffv} !== 4'b0 || b_tt !== 32'h0 || b_mcnt !== 6'd0) begin
            errors++; $display("FAIL reset_b flags=%b tt=%h mcnt=%0d want all 0", {b_busy, b_done, b_pass, b_ffv}, b_tt, b_mcnt);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_loopback;
        int cyc, bsy;
        model_a = GOLD;
        run_a(cyc, bsy);
        checks++;
        if (cyc !== 97) begin errors++; $display("FAIL loop_latency got %0d want 97", cyc); end
        checks++;
        if (bsy !== 96) begin errors++; $display("FAIL loop_busy_cycles got %0d want 96", bsy); end
        checks++;
        if (a_tt !== GOLD) begin errors++; $display("FAIL loop_table got %h want %h", a_tt, GOLD); end
        checks++;
        if (a_pass !== 1'b1 || a_mcnt !== 6'd0 || a_ffv !== 1'b0) begin
            errors++; $display("FAIL loop_result pass=%b mcnt=%0d ffv=%b want 1 0 0", a_pass, a_mcnt, a_ffv);
        end
        checks++;
        if (a_vec !== 5'h1F || a_busy !== 1'b0) begin
            errors++; $display("FAIL loop_hold vec=%0d busy=%b want 31 0", a_vec, a_busy);
        end
    endtask

    task automatic test_single_one;
        int cyc, bsy;
        model_a = 32'h0000_0080;
        run_a(cyc, bsy);
        checks++;
        if (a_tt !== 32'h0000_0080) begin errors++; $display("FAIL one_table got %h want 00000080", a_tt); end
        checks++;
        if (a_mcnt !== 6'd19) begin errors++; $display("FAIL one_mcnt got %0d want 19", a_mcnt); end
        checks++;
        if (a_ff !== 5'd0 || a_ffv !== 1'b1) begin
            errors++; $display("FAIL one_first got ff=%0d vld=%b want 0 1", a_ff, a_ffv);
        end
        checks++;
        if (a_pass !== 1'b0 || a_done !== 1'b1) begin
            errors++; $display("FAIL one_pass got pass=%b done=%b want 0 1", a_pass, a_done);
        end
    endtask

    task automatic test_settle0;
        int cyc;
        model_b = GOLD ^ 32'h0040_0000;
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        cyc = 0;
        while (!b_done && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (cyc !== 65) begin errors++; $display("FAIL s0_latency got %0d want 65", cyc); end
        checks++;
        if (b_mcnt !== 6'd1 || b_ff !== 5'd22 || b_ffv !== 1'b1) begin
            errors++; $display("FAIL s0_first got mcnt=%0d ff=%0d vld=%b want 1 22 1", b_mcnt, b_ff, b_ffv);
        end
        checks++;
        if (b_pass !== 1'b0 || b_tt !== (GOLD ^ 32'h0040_0000)) begin
            errors++; $display("FAIL s0_table got pass=%b tt=%h want 0 %h", b_pass, b_tt, GOLD ^ 32'h0040_0000);
        end
    endtask

    task automatic test_reset_mid;
        int n, cyc, bsy;
        model_a = GOLD;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        n = 0;
        while (a_vec !== 5'd10 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (a_vec !== 5'd10) begin errors++; $display("FAIL rst_mid_reach got vec=%0d want 10", a_vec); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++;
        if ({a_busy, a_done, a_pass, a_ffv} !== 4'b0 || a_tt !== 32'h0 || a_mcnt !== 6'd0 || a_ff !== 5'd0 || a_vec !== 5'd0) begin
            errors++; $display("FAIL rst_mid_clear flags=%b tt=%h mcnt=%0d ff=%0d vec=%0d want all 0",
                               {a_busy, a_done, a_pass, a_ffv}, a_tt, a_mcnt, a_ff, a_vec);
        end
        run_a(cyc, bsy);
        checks++;
        if (cyc !== 97 || a_pass !== 1'b1 || a_tt !== GOLD) begin
            errors++; $display("FAIL rst_mid_rerun got cyc=%0d pass=%b tt=%h want 97 1 %h", cyc, a_pass, a_tt, GOLD);
        end
    endtask

    task automatic test_abort;
        int n;
        model_a = GOLD;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        n = 0;
        while (a_vec !== 5'd5 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        abort = 1'b1;
        start_a = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        start_a = 1'b0;
        checks++;
        if (a_busy !== 1'b0 || a_done !== 1'b0 || a_pass !== 1'b0) begin
            errors++; $display("FAIL abort_flags got busy=%b done=%b pass=%b want 0 0 0", a_busy, a_done, a_pass);
        end
        checks++;
        if (a_tt !== 32'h0000_001F || a_mcnt !== 6'd0) begin
            errors++; $display("FAIL abort_partial got tt=%h mcnt=%0d want 0000001f 0", a_tt, a_mcnt);
        end
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        checks++;
        if (a_busy !== 1'b1) begin errors++; $display("FAIL abort_restart_busy got %b want 1", a_busy); end
        @(posedge clk); #1;
        checks++;
        if (a_vec !== 5'd0) begin errors++; $display("FAIL abort_restart_idx got %0d want 0", a_vec); end
        n = 0;
        while (!a_done && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (a_pass !== 1'b1 || a_tt !== GOLD) begin
            errors++; $display("FAIL abort_rerun got pass=%b tt=%h want 1 %h", a_pass, a_tt, GOLD);
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        model_a = GOLD;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        cyc = 0;
        while (!a_done && cyc < 200) begin
            start_a = (cyc == 20 || cyc == 50);
            @(posedge clk); #1;
            cyc++;
        end
        start_a = 1'b0;
        checks++;
        if (cyc !== 97) begin errors++; $display("FAIL b2b_latency got %0d want 97", cyc); end
        checks++;
        if (a_pass !== 1'b1 || a_tt !== GOLD) begin
            errors++; $display("FAIL b2b_result got pass=%b tt=%h want 1 %h", a_pass, a_tt, GOLD);
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_single_one();
        test_settle0();
        test_reset_mid();
        test_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
